stream_to_udp: RTL and testbench

// RX counterpart of the UDP TX stream path: takes an IPv4 payload stream (UDP header + data) with its IP-level

---
 rtl/stream_to_udp.sv | 224 ++++++++++++++++++++++
 tb/tb_stream_to_udp.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_to_udp.sv
// rtl/stream_to_udp.sv - UDP RX: parse/strip the 8-byte UDP header, realign payload, verify checksum
// Optional checksum verification is built when STREAM_TO_UDP_CSUM_CHECK_EN is defined.
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif
`ifndef TOT_LEN_W
`define TOT_LEN_W 16
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif
`ifndef TRACKER_STATS_W
`define TRACKER_STATS_W 64
`endif

module stream_to_udp #(
  parameter int DATA_WIDTH = `MAC_INTERFACE_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        src_stream_to_udp_hdr_val,
  input  logic [`IP_ADDR_W-1:0]       src_stream_to_udp_src_ip,
  input  logic [`IP_ADDR_W-1:0]       src_stream_to_udp_dst_ip,
  input  logic [`TOT_LEN_W-1:0]       src_stream_to_udp_data_len,
  input  logic [`TRACKER_STATS_W-1:0] src_stream_to_udp_timestamp,
  output logic                        stream_to_udp_src_hdr_rdy,
  input  logic                        src_stream_to_udp_data_val,
  output logic                        src_stream_to_udp_data_rdy,
  input  logic [DATA_WIDTH-1:0]       src_stream_to_udp_data,
  input  logic                        src_stream_to_udp_data_last,
  input  logic [`MAC_PADBYTES_W-1:0]  src_stream_to_udp_data_padbytes,
  output logic                        stream_to_udp_dst_hdr_val,
  input  logic                        stream_to_udp_dst_hdr_rdy,
  output logic [`IP_ADDR_W-1:0]       stream_to_udp_dst_src_ip,
  output logic [`IP_ADDR_W-1:0]       stream_to_udp_dst_dst_ip,
  output logic [63:0]                 stream_to_udp_dst_udp_hdr,
  output logic [`TRACKER_STATS_W-1:0] stream_to_udp_dst_timestamp,
  output logic                        stream_to_udp_dst_val,
  input  logic                        stream_to_udp_dst_rdy,
  output logic [DATA_WIDTH-1:0]       stream_to_udp_dst_data,
  output logic                        stream_to_udp_dst_last,
  output logic [`MAC_PADBYTES_W-1:0]  stream_to_udp_dst_padbytes,
  output logic                        stream_to_udp_dst_err
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int CW  = DATA_WIDTH - 64;
  localparam int TCW = $clog2(2 * NB + 1);
  localparam int PW  = `MAC_PADBYTES_W;

  typedef enum logic [2:0] {IDLE, FIRST, OUT_HDR, DATA, TAIL} state_t;
  state_t state, state_n;

  logic                        run_r;
  logic [`IP_ADDR_W-1:0]       src_ip_r, dst_ip_r;
  logic [`TOT_LEN_W-1:0]       data_len_r;
  logic [`TRACKER_STATS_W-1:0] ts_r;
  logic [63:0]                 udp_hdr_r;
  logic [CW-1:0]               carry_r;
  logic [2*DATA_WIDTH-1:0]     tail_r;
  logic [TCW-1:0]              tail_cnt_r;
  logic                        tail_idx_r;
  logic                        last_seen_r;

  logic [DATA_WIDTH-1:0] in_mask, in_masked;
  logic [TCW-1:0]        pad_ext, first_cnt, data_cnt;
  logic                  tail_two, tail_last;
  logic [PW-1:0]         tail_pad;
  logic                  hdr_acc, in_acc;
  logic                  len_err, csum_err, pkt_err;

  // Pad bytes of the last input beat are zeroed so they never reach the sum or the output.
  assign in_mask   = src_stream_to_udp_data_last ?
                     ({DATA_WIDTH{1'b1}} << {src_stream_to_udp_data_padbytes, 3'b000}) :
                     {DATA_WIDTH{1'b1}};
  assign in_masked = src_stream_to_udp_data & in_mask;

  assign pad_ext   = TCW'(src_stream_to_udp_data_padbytes);
  assign first_cnt = (pad_ext > TCW'(NB - 8)) ? '0 : TCW'(NB - 8) - pad_ext;
  assign data_cnt  = TCW'(2 * NB - 8) - pad_ext;
  assign tail_two  = tail_cnt_r > TCW'(NB);
  assign tail_last = !tail_two || tail_idx_r;
  // beats*NB - T modulo NB; a zero-length tail wraps to 0
  assign tail_pad  = PW'(-tail_cnt_r);

  assign hdr_acc = src_stream_to_udp_hdr_val && stream_to_udp_src_hdr_rdy;
  assign in_acc  = src_stream_to_udp_data_val && src_stream_to_udp_data_rdy;

  assign len_err = (udp_hdr_r[31:16] != data_len_r) || (data_len_r < `TOT_LEN_W'(8));
  assign pkt_err = len_err || csum_err;

  assign stream_to_udp_dst_src_ip    = src_ip_r;
  assign stream_to_udp_dst_dst_ip    = dst_ip_r;
  assign stream_to_udp_dst_udp_hdr   = udp_hdr_r;
  assign stream_to_udp_dst_timestamp = ts_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      run_r       <= 1'b0;
      src_ip_r    <= '0;
      dst_ip_r    <= '0;
      data_len_r  <= '0;
      ts_r        <= '0;
      udp_hdr_r   <= '0;
      carry_r     <= '0;
      tail_r      <= '0;
      tail_cnt_r  <= '0;
      tail_idx_r  <= 1'b0;
      last_seen_r <= 1'b0;
    end else begin
      state <= state_n;
      run_r <= 1'b1;
      if (state == IDLE && hdr_acc) begin
        src_ip_r    <= src_stream_to_udp_src_ip;
        dst_ip_r    <= src_stream_to_udp_dst_ip;
        data_len_r  <= src_stream_to_udp_data_len;
        ts_r        <= src_stream_to_udp_timestamp;
        last_seen_r <= 1'b0;
        tail_idx_r  <= 1'b0;
      end
      if (state == FIRST && in_acc) begin
        udp_hdr_r <= in_masked[DATA_WIDTH-1 -: 64];
        carry_r   <= in_masked[CW-1:0];
        if (src_stream_to_udp_data_last) begin
          last_seen_r <= 1'b1;
          tail_r      <= {in_masked[CW-1:0], {(DATA_WIDTH + 64){1'b0}}};
          tail_cnt_r  <= first_cnt;
        end
      end
      if (state == DATA && in_acc) begin
        carry_r <= src_stream_to_udp_data[CW-1:0];
        if (src_stream_to_udp_data_last) begin
          tail_r     <= {carry_r, in_masked, 64'b0};
          tail_cnt_r <= data_cnt;
        end
      end
      if (state == TAIL && stream_to_udp_dst_rdy && !tail_last)
        tail_idx_r <= 1'b1;
    end
  end

  always_comb begin
    state_n                    = state;
    stream_to_udp_src_hdr_rdy  = 1'b0;
    src_stream_to_udp_data_rdy = 1'b0;
    stream_to_udp_dst_hdr_val  = 1'b0;
    stream_to_udp_dst_val      = 1'b0;
    stream_to_udp_dst_data     = '0;
    stream_to_udp_dst_last     = 1'b0;
    stream_to_udp_dst_padbytes = '0;
    stream_to_udp_dst_err      = 1'b0;
    case (state)
      IDLE: begin
        stream_to_udp_src_hdr_rdy = run_r;
        if (src_stream_to_udp_hdr_val && run_r) state_n = FIRST;
      end
      FIRST: begin
        src_stream_to_udp_data_rdy = 1'b1;
        if (src_stream_to_udp_data_val) state_n = OUT_HDR;
      end
      OUT_HDR: begin
        stream_to_udp_dst_hdr_val = 1'b1;
        if (stream_to_udp_dst_hdr_rdy) state_n = last_seen_r ? TAIL : DATA;
      end
      DATA: begin
        // The last input beat only feeds the tail register, so it never waits on the consumer.
        stream_to_udp_dst_val      = src_stream_to_udp_data_val && !src_stream_to_udp_data_last;
        src_stream_to_udp_data_rdy = stream_to_udp_dst_rdy || src_stream_to_udp_data_last;
        stream_to_udp_dst_data     = {carry_r, src_stream_to_udp_data[DATA_WIDTH-1 -: 64]};
        if (src_stream_to_udp_data_val && src_stream_to_udp_data_last) state_n = TAIL;
      end
      TAIL: begin
        stream_to_udp_dst_val      = 1'b1;
        stream_to_udp_dst_data     = tail_idx_r ? tail_r[DATA_WIDTH-1:0] : tail_r[2*DATA_WIDTH-1 -: DATA_WIDTH];
        stream_to_udp_dst_last     = tail_last;
        stream_to_udp_dst_padbytes = tail_last ? tail_pad : '0;
        stream_to_udp_dst_err      = tail_last && pkt_err;
        if (stream_to_udp_dst_rdy && tail_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef STREAM_TO_UDP_CSUM_CHECK_EN
  localparam int SW = 16 + $clog2(NB / 2 + 2);

  logic [15:0]   csum_acc;
  logic [SW-1:0] seed_sum, beat_sum;

  function automatic logic [15:0] fold(input logic [SW-1:0] s);
    logic [16:0] f;
    f = {1'b0, s[15:0]} + 17'(s[SW-1:16]);
    return f[15:0] + {15'b0, f[16]};
  endfunction

  always_comb begin
    seed_sum = SW'(src_stream_to_udp_src_ip[31:16]) + SW'(src_stream_to_udp_src_ip[15:0]) +
               SW'(src_stream_to_udp_dst_ip[31:16]) + SW'(src_stream_to_udp_dst_ip[15:0]) +
               SW'(16'h0011) + SW'(src_stream_to_udp_data_len);
    beat_sum = SW'(csum_acc);
    for (int i = 0; i < NB / 2; i++)
      beat_sum = beat_sum + SW'(in_masked[16*i +: 16]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      csum_acc <= '0;
    else if (state == IDLE && hdr_acc)
      csum_acc <= fold(seed_sum);
    else if ((state == FIRST || state == DATA) && in_acc)
      csum_acc <= fold(beat_sum);
  end

  // A zero checksum field means the sender disabled the checksum.
  assign csum_err = (udp_hdr_r[15:0] != 16'h0000) && (csum_acc != 16'hFFFF);
`else
  assign csum_err = 1'b0;
`endif

endmodule

// File: tb/tb_stream_to_udp.sv
// tb/tb_stream_to_udp.sv - randomized bench for stream_to_udp against a byte-level packet model
module tb_stream_to_udp;
  localparam int W  = 256;
  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hdr_val = 1'b0;
  logic [31:0]   src_ip = '0, dst_ip = '0;
  logic [15:0]   data_len = '0;
  logic [63:0]   ts = '0;
  logic          hdr_rdy;
  logic          src_val = 1'b0;
  logic          src_rdy;
  logic [W-1:0]  src_data = '0;
  logic          src_last = 1'b0;
  logic [4:0]    src_pad = '0;
  logic          out_hdr_val;
  logic          out_hdr_rdy = 1'b0;
  logic [31:0]   out_src_ip, out_dst_ip;
  logic [63:0]   out_udp_hdr, out_ts;
  logic          out_val;
  logic          out_rdy = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic [4:0]    out_pad;
  logic          out_err;

  stream_to_udp dut (
    .clk                             (clk),
    .rst                             (rst),
    .src_stream_to_udp_hdr_val       (hdr_val),
    .src_stream_to_udp_src_ip        (src_ip),
    .src_stream_to_udp_dst_ip        (dst_ip),
    .src_stream_to_udp_data_len      (data_len),
    .src_stream_to_udp_timestamp     (ts),
    .stream_to_udp_src_hdr_rdy       (hdr_rdy),
    .src_stream_to_udp_data_val      (src_val),
    .src_stream_to_udp_data_rdy      (src_rdy),
    .src_stream_to_udp_data          (src_data),
    .src_stream_to_udp_data_last     (src_last),
    .src_stream_to_udp_data_padbytes (src_pad),
    .stream_to_udp_dst_hdr_val       (out_hdr_val),
    .stream_to_udp_dst_hdr_rdy       (out_hdr_rdy),
    .stream_to_udp_dst_src_ip        (out_src_ip),
    .stream_to_udp_dst_dst_ip        (out_dst_ip),
    .stream_to_udp_dst_udp_hdr       (out_udp_hdr),
    .stream_to_udp_dst_timestamp     (out_ts),
    .stream_to_udp_dst_val           (out_val),
    .stream_to_udp_dst_rdy           (out_rdy),
    .stream_to_udp_dst_data          (out_data),
    .stream_to_udp_dst_last          (out_last),
    .stream_to_udp_dst_padbytes      (out_pad),
    .stream_to_udp_dst_err           (out_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] sip, dip; logic [63:0] hdr, ts; } hdr_exp_t;
  typedef struct { logic [W-1:0] data; logic last; logic [4:0] pad; logic err; } beat_exp_t;

  hdr_exp_t    hq[$];
  beat_exp_t   bq[$];
  logic [7:0]  pkt[0:1535];
  int          n_tests = 0;
  int          n_fail = 0;
  bit          bp = 1'b0;
  bit          ignore_out = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ocsum(input logic [31:0] s);
    while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return s[15:0];
  endfunction

  function automatic logic [31:0] sum_bytes(input int n);
    logic [31:0] s = 0;
    for (int i = 0; i < n; i += 2)
      s += {16'h0, pkt[i], (i + 1 < n) ? pkt[i+1] : 8'h00};
    return s;
  endfunction

  task automatic wait_rdy(input bit data_side, input string tag);
    int  cyc = 0;
    bit  acc;
    do begin
      @(negedge clk);
      acc = data_side ? src_rdy : hdr_rdy;
      @(posedge clk); #1;
      cyc++;
    end while (!acc && cyc < 5000);
    if (!acc) check(tag, 0, 1);
  endtask

  task automatic send_packet(input int plen, input logic [15:0] sport, input logic [15:0] dport,
                             input bit flip, input bit zero_cs, input bit bad_len);
    logic [31:0] sip, dip, ps;
    logic [63:0] t;
    logic [15:0] dlen, ulen, cs;
    logic [W-1:0] d;
    int n, inb, onb;
    bit err;
    beat_exp_t b;
    hdr_exp_t h;
    sip = $urandom; dip = $urandom; t = {$urandom, $urandom};
    n = plen + 8;
    dlen = 16'(n);
    ulen = bad_len ? dlen + 16'd2 : dlen;
    for (int i = 8; i < n; i++) pkt[i] = 8'($urandom);
    pkt[0] = sport[15:8]; pkt[1] = sport[7:0];
    pkt[2] = dport[15:8]; pkt[3] = dport[7:0];
    pkt[4] = ulen[15:8];  pkt[5] = ulen[7:0];
    pkt[6] = 8'h00;       pkt[7] = 8'h00;
    ps = {16'h0, sip[31:16]} + {16'h0, sip[15:0]} + {16'h0, dip[31:16]} + {16'h0, dip[15:0]} +
         32'h11 + {16'h0, dlen};
    cs = ~ocsum(ps + sum_bytes(n));
    if (cs == 16'h0) cs = 16'hFFFF;
    if (zero_cs) cs = 16'h0;
    pkt[6] = cs[15:8]; pkt[7] = cs[7:0];
    if (flip && plen > 0) begin
      int k;
      k = 8 + int'($urandom_range(plen - 1));
      pkt[k] ^= 8'(1 << $urandom_range(7));
    end
    err = (ulen != dlen);
`ifdef STREAM_TO_UDP_CSUM_CHECK_EN
    if (cs != 16'h0 && ocsum(ps + sum_bytes(n)) != 16'hFFFF) err = 1'b1;
`endif
    h.sip = sip; h.dip = dip; h.ts = t;
    h.hdr = {pkt[0], pkt[1], pkt[2], pkt[3], ulen, cs};
    hq.push_back(h);
    onb = (plen == 0) ? 1 : (plen + NB - 1) / NB;
    for (int bi = 0; bi < onb; bi++) begin
      d = '0;
      for (int j = 0; j < NB; j++)
        if (bi * NB + j < plen) d[W-1-8*j -: 8] = pkt[8 + bi * NB + j];
      b.data = d;
      b.last = (bi == onb - 1);
      b.pad  = b.last ? 5'((onb * NB - plen) % NB) : 5'd0;
      b.err  = b.last ? err : 1'b0;
      bq.push_back(b);
    end

    hdr_val = 1'b1; src_ip = sip; dst_ip = dip; data_len = dlen; ts = t;
    wait_rdy(1'b0, "hdr_accept_timeout");
    hdr_val = 1'b0;
    inb = (n + NB - 1) / NB;
    for (int bi = 0; bi < inb; bi++) begin
      if (bp && $urandom_range(3) == 0) begin
        src_val = 1'b0;
        repeat ($urandom_range(2, 1)) begin @(posedge clk); #1; end
      end
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      for (int j = 0; j < NB; j++)
        if (bi * NB + j < n) d[W-1-8*j -: 8] = pkt[bi * NB + j];
      src_data = d;
      src_last = (bi == inb - 1);
      src_pad  = src_last ? 5'(inb * NB - n) : 5'($urandom);
      src_val  = 1'b1;
      wait_rdy(1'b1, "data_accept_timeout");
    end
    src_val = 1'b0; src_last = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((hq.size() != 0 || bq.size() != 0) && c < 20000) begin @(posedge clk); #1; c++; end
    check("drain_outstanding", W'(hq.size() + bq.size()), '0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      out_rdy     = bp ? ($urandom_range(3) != 0) : 1'b1;
      out_hdr_rdy = bp ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  initial begin
    hdr_exp_t  h;
    beat_exp_t b;
    forever begin
      @(negedge clk);
      if (!rst && !ignore_out) begin
        if (out_hdr_val && out_hdr_rdy) begin
          if (hq.size() == 0) check("unexpected_hdr", 1, 0);
          else begin
            h = hq.pop_front();
            check("out_src_ip", out_src_ip, h.sip);
            check("out_dst_ip", out_dst_ip, h.dip);
            check("out_udp_hdr", out_udp_hdr, h.hdr);
            check("out_timestamp", out_ts, h.ts);
          end
        end
        if (out_val && out_rdy) begin
          if (bq.size() == 0) check("unexpected_beat", 1, 0);
          else begin
            b = bq.pop_front();
            check("out_data", out_data, b.data);
            check("out_last", out_last, b.last);
            check("out_padbytes", out_pad, b.pad);
            check("out_err", out_err, b.err);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_hdr_rdy", hdr_rdy, 0);
    check("rst_data_rdy", src_rdy, 0);
    check("rst_dst_hdr_val", out_hdr_val, 0);
    check("rst_dst_val", out_val, 0);
    check("rst_dst_last", out_last, 0);
    check("rst_dst_err", out_err, 0);
    check("rst_dst_data", out_data, 0);
    check("rst_dst_pad", out_pad, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_hdr_rdy", hdr_rdy, 1);

    send_packet(100, 16'd1234, 16'd80, 0, 0, 0);
    send_packet(100, 16'd1234, 16'd80, 1, 0, 0);
    send_packet(24, 16'd5000, 16'd53, 0, 0, 0);
    send_packet(56, 16'd7, 16'd9, 0, 0, 0);
    send_packet(0, 16'd1, 16'd2, 0, 0, 0);
    send_packet(1, 16'd3, 16'd4, 0, 0, 0);
    send_packet(40, 16'd11, 16'd12, 0, 0, 1);
    send_packet(33, 16'd13, 16'd14, 1, 1, 0);
    wait_drain();

    bp = 1'b1;
    for (int p = 0; p < 500; p++)
      send_packet(($urandom_range(3) == 0) ? int'($urandom_range(64)) : int'($urandom_range(1472)),
                  16'($urandom), 16'($urandom),
                  $urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(15) == 0);
    wait_drain();

    bp = 1'b0;
    ignore_out = 1'b1;
    hdr_val = 1'b1; src_ip = $urandom; dst_ip = $urandom; data_len = 16'd300; ts = '0;
    wait_rdy(1'b0, "rst_pkt_hdr_timeout");
    hdr_val = 1'b0;
    for (int bi = 0; bi < 3; bi++) begin
      src_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      src_last = 1'b0; src_val = 1'b1;
      wait_rdy(1'b1, "rst_pkt_data_timeout");
    end
    check("pre_rst_in_data_val", out_val, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_dst_val", out_val, 0);
    check("mid_rst_dst_hdr_val", out_hdr_val, 0);
    check("mid_rst_data_rdy", src_rdy, 0);
    check("mid_rst_hdr_rdy", hdr_rdy, 0);
    src_val = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    ignore_out = 1'b0;
    send_packet(200, 16'd4321, 16'd8080, 1, 1, 0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
